// File: rtl/mips_debug_pkg.sv
// Shared types and constants for the MIPS debug-side register dump path.
package mips_debug_pkg;

   localparam int NB_BYTE_DEF    = 8;
   localparam int NB_DATA_DEF    = 32;
   localparam int BYTES_PER_WORD = NB_DATA_DEF / NB_BYTE_DEF;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WAIT,
      SEND,
      DONE
   } state_t;

   function automatic int bytes_per_word(input int nb_data, input int nb_byte);
      return nb_data / nb_byte;
   endfunction

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Register-file read port plus byte stream towards the debug UART transmitter.
interface regfile_dump_reader_if
   import mips_debug_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF,
   parameter int NB_ADDR = 5,
   parameter int NB_BYTE = NB_BYTE_DEF
);

   logic [NB_ADDR-1:0] rd_addr;
   logic [NB_DATA-1:0] rd_data;
   logic [NB_BYTE-1:0] tx_data;
   logic               tx_valid;
   logic               tx_ready;

   // master: the dump reader; slave: register file and transmitter side
   modport master (
      output rd_addr, tx_data, tx_valid,
      input  rd_data, tx_ready
   );

   modport slave (
      input  rd_addr, tx_data, tx_valid,
      output rd_data, tx_ready
   );

endinterface

// File: rtl/regfile_dump_reader_serializer.sv
// Word-to-byte serializer: loads a word, emits it MSB-first on a valid/ready stream.
module word_serializer
   import mips_debug_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF,
   parameter int NB_BYTE = NB_BYTE_DEF
) (
   input  logic               clk,
   input  logic               i_rst,
   input  logic               i_load,
   input  logic [NB_DATA-1:0] i_word,
   output logic [NB_BYTE-1:0] o_data,
   output logic               o_valid,
   input  logic               i_ready,
   output logic               o_last_accepted
);

   localparam int                BPW      = bytes_per_word(NB_DATA, NB_BYTE);
   localparam int                NB_IDX   = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(BPW - 1);

   logic [NB_DATA-1:0] shreg;
   logic [NB_IDX-1:0]  byte_idx;
   logic               valid_q;
   logic               accept;

   assign accept          = valid_q && i_ready;
   assign o_last_accepted = accept && (byte_idx == LAST_IDX);
   assign o_valid         = valid_q;
   assign o_data          = shreg[NB_DATA-1 -: NB_BYTE];

   // NOTE: state is updated with <= so every flop samples pre-edge values, as real registers do.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         shreg    <= '0;
         byte_idx <= '0;
         valid_q  <= 1'b0;
      end else if (i_load) begin
         shreg    <= i_word;
         byte_idx <= '0;
         valid_q  <= 1'b1;
      end else if (accept) begin
         shreg    <= shreg << NB_BYTE;
         byte_idx <= byte_idx + 1'b1;
         if (byte_idx == LAST_IDX) valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks every register-file address and streams each word as bytes to the debug TX path.
module regfile_dump_reader
   import mips_debug_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF,
   parameter int NB_ADDR = 5,
   parameter int NB_BYTE = NB_BYTE_DEF
) (
   input  logic                  clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   output logic                  o_busy,
   output logic                  o_done,
   regfile_dump_reader_if.master bus
);

   // One extra counter bit keeps the last-register compare free of wrap ambiguity.
   localparam logic [NB_ADDR:0] LAST_ADDR = (NB_ADDR + 1)'((1 << NB_ADDR) - 1);

   state_t             state, state_next;
   logic [NB_ADDR:0]   counter;
   logic               load;
   logic               last_accepted;
   logic               last_reg;

   assign last_reg    = (counter == LAST_ADDR);
   assign bus.rd_addr = counter[NB_ADDR-1:0];

   always_ff @(posedge clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (i_rst)                                     counter <= '0;
      else if (state == IDLE && i_start)             counter <= '0;
      else if (state == SEND && last_accepted && !last_reg) counter <= counter + 1'b1;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      o_done     = 1'b0;
      o_busy     = (state != IDLE);
      case (state)
         IDLE: if (i_start) state_next = ADDR;
         ADDR: state_next = WAIT;
         WAIT: begin
            load       = 1'b1;
            state_next = SEND;
         end
         SEND: if (last_accepted) state_next = last_reg ? DONE : ADDR;
         DONE: begin
            o_done     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   word_serializer #(
      .NB_DATA (NB_DATA),
      .NB_BYTE (NB_BYTE)
   ) u_serializer (
      .clk             (clk),
      .i_rst           (i_rst),
      .i_load          (load),
      .i_word          (bus.rd_data),
      .o_data          (bus.tx_data),
      .o_valid         (bus.tx_valid),
      .i_ready         (bus.tx_ready),
      .o_last_accepted (last_accepted)
   );

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized self-checking bench for regfile_dump_reader against a byte-stream reference model.
module tb_regfile_dump_reader;

   localparam int NB_DATA = 32;
   localparam int NB_ADDR = 5;
   localparam int NB_BYTE = 8;
   localparam int NREG    = 1 << NB_ADDR;
   localparam int BPW     = NB_DATA / NB_BYTE;
   localparam int NBYTES  = NREG * BPW;
   localparam int MIN_DONE_CYCLE = NREG * (2 + BPW) + 1;

   logic clk = 1'b0;
   logic i_rst;
   logic i_start;
   logic o_busy;
   logic o_done;

   logic [NB_DATA-1:0] regs [NREG];

   int n_cmp = 0;
   int n_err = 0;

   regfile_dump_reader_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_BYTE(NB_BYTE)) bus ();

   regfile_dump_reader #(
      .NB_DATA (NB_DATA),
      .NB_ADDR (NB_ADDR),
      .NB_BYTE (NB_BYTE)
   ) dut (
      .clk     (clk),
      .i_rst   (i_rst),
      .i_start (i_start),
      .o_busy  (o_busy),
      .o_done  (o_done),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Register file model with a registered read port.
   always @(posedge clk) bus.rd_data <= regs[bus.rd_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_rd_addr"}, 32'(bus.rd_addr), 0);
      check({tag, "_tx_data"}, 32'(bus.tx_data), 0);
      check({tag, "_tx_valid"}, 32'(bus.tx_valid), 0);
      check({tag, "_busy"}, 32'(o_busy), 0);
      check({tag, "_done"}, 32'(o_done), 0);
   endtask

   // Starts a dump and follows it to completion, comparing the accepted bytes
   // against the register contents split MSB-first.
   task automatic run_dump(input bit rnd_ready, input int stall_pos, input int stall_len,
                           input int restart_at, input bit exact_timing);
      logic [7:0] got[$];
      logic [7:0] exp[$];
      int         done_cnt = 0;
      int         done_cyc = -1;
      int         stalls   = 0;
      logic       pv = 1'b0, pr = 1'b0;
      logic [7:0] pd = '0;
      logic       r;

      for (int k = 0; k < NREG; k++)
         for (int b = 0; b < BPW; b++)
            exp.push_back(8'((regs[k] >> (NB_BYTE * (BPW - 1 - b))) & 32'hFF));

      @(negedge clk);
      i_start = 1'b1;
      for (int c = 1; c <= 4000; c++) begin
         @(negedge clk);
         i_start = 1'b0;
         if (c == 1) begin
            check("busy_at_start", 32'(o_busy), 1);
            check("addr_at_start", 32'(bus.rd_addr), 0);
         end
         if (pv && !pr) begin
            check("hold_valid", 32'(bus.tx_valid), 1);
            check("hold_data", 32'(bus.tx_data), 32'(pd));
         end
         if (o_done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (done_cyc >= 0 && c == done_cyc + 1) begin
            check("busy_after_done", 32'(o_busy), 0);
            check("valid_after_done", 32'(bus.tx_valid), 0);
            break;
         end
         r = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (got.size() == stall_pos && bus.tx_valid && stalls < stall_len) begin
            r = 1'b0;
            stalls++;
            if (stalls == stall_len) begin
               check("stall_valid", 32'(bus.tx_valid), 1);
               check("stall_addr", 32'(bus.rd_addr), 32'(stall_pos / BPW));
               check("stall_data", 32'(bus.tx_data), 32'(exp[stall_pos]));
            end
         end
         bus.tx_ready = r;
         if (restart_at >= 0 && got.size() == restart_at) i_start = 1'b1;
         if (bus.tx_valid && r) got.push_back(bus.tx_data);
         pv = bus.tx_valid;
         pr = r;
         pd = bus.tx_data;
      end
      i_start      = 1'b0;
      bus.tx_ready = 1'b1;

      check("byte_count", 32'(got.size()), NBYTES);
      check("done_pulses", 32'(done_cnt), 1);
      if (exact_timing) check("done_cycle", 32'(done_cyc), MIN_DONE_CYCLE);
      for (int i = 0; i < got.size() && i < NBYTES; i++)
         check($sformatf("byte%0d", i), 32'(got[i]), 32'(exp[i]));
   endtask

   initial begin
      bit found;

      i_rst        = 1'b1;
      i_start      = 1'b0;
      bus.tx_ready = 1'b1;
      for (int k = 0; k < NREG; k++) regs[k] = 32'h1000_0000 + k;
      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      i_rst = 1'b0;
      @(negedge clk);

      // Full dump, ready held high: minimum latency and incrementing pattern.
      regs[NREG-1] = 32'hFFFF_FFFF;
      run_dump(1'b0, -1, 0, -1, 1'b1);

      // Random backpressure with a known word at register 5.
      regs[5] = 32'hDEAD_BEEF;
      run_dump(1'b1, -1, 0, -1, 1'b0);

      // Long stall on byte 2 of register 7.
      for (int k = 0; k < NREG; k++) regs[k] = $urandom;
      run_dump(1'b0, 7 * BPW + 2, 50, -1, 1'b0);

      // Start pulses while busy (at register 3) must be ignored.
      run_dump(1'b1, -1, 0, 3 * BPW, 1'b0);

      // Reset in the middle of sending register 12, then a clean restart.
      for (int k = 0; k < NREG; k++) regs[k] = $urandom;
      found = 1'b0;
      @(negedge clk);
      i_start = 1'b1;
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         i_start = 1'b0;
         if (bus.rd_addr == 5'd12 && bus.tx_valid) begin
            found = 1'b1;
            break;
         end
      end
      check("reached_reg12", 32'(found), 1);
      i_rst = 1'b1;
      @(negedge clk);
      check_idle_outputs("midreset");
      i_rst = 1'b0;
      run_dump(1'b0, -1, 0, -1, 1'b1);

      // Start held high: next dump begins one IDLE cycle after DONE.
      found = 1'b0;
      @(negedge clk);
      i_start = 1'b1;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         if (o_done) begin
            found = 1'b1;
            check("held_done_cycle", 32'(c), MIN_DONE_CYCLE);
            break;
         end
      end
      check("held_done_seen", 32'(found), 1);
      @(negedge clk);
      check("held_idle_gap", 32'(o_busy), 0);
      @(negedge clk);
      check("held_restart_busy", 32'(o_busy), 1);
      check("held_restart_addr", 32'(bus.rd_addr), 0);
      check("held_restart_valid", 32'(bus.tx_valid), 0);
      i_start = 1'b0;
      i_rst   = 1'b1;
      @(negedge clk);
      i_rst = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
